// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential accumulator ALU.
//   - OP_* : 3-bit operation codes (all eight codes are meaningful)
//   - state_t : control FSM states IDLE / MUL / DONE
//   - flags_t : status flag bundle {carry, ovf, zero}
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_ACC = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/seq_mul_shift_add.sv
// ---------------------------------------------------------------------------
// seq_mul_shift_add
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           load a/b, clear the product, set the counter to N
//   a, b [N-1:0]    multiplicand / multiplier, sampled on the start edge
//   busy            iterations remain (counter != 0)
//   done            the step executing this cycle is the final one
//   product [2N-1:0] product including this cycle's step; exact while done
// ---------------------------------------------------------------------------
module seq_mul_shift_add #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] prod;
    logic [CW-1:0]  count;
    logic [2*N-1:0] step_prod;

    // The product is exposed with the current step already folded in, so the
    // controller can capture the final value on the same edge that performs
    // the last iteration instead of waiting an extra cycle.
    always_comb begin
        step_prod = prod + (mplier[0] ? mcand : '0);
        busy      = (count != '0);
        done      = (count == CW'(1));
        product   = step_prod;
    end

    // Classic shift-add: add the shifted multiplicand whenever the current
    // multiplier LSB is set, then shift both operands for the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            count  <= CW'(N);
        end else if (busy) begin
            prod   <= step_prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_acc.sv
// ---------------------------------------------------------------------------
// alu_seq_acc
// Sequential N-bit ALU with valid/ready handshake, accumulator, status flags
// and an iterative multiplier. One operation in flight at a time.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operation handshake (in_ready high only in IDLE)
//   A, B [N-1:0], opcode[3] operands and operation select
//   out_valid / out_ready   result handshake; result held until taken
//   result [N-1:0]          operation result
//   carry, ovf, zero        status flags registered alongside the result
// ---------------------------------------------------------------------------
module alu_seq_acc #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         ovf,
    output logic         zero
);

    import alu_pkg::*;

    state_t         state;
    logic [N-1:0]   acc;
    logic [N-1:0]   result_q;
    flags_t         flags_q;

    logic           accept;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [2*N-1:0] mul_product;

    logic [N-1:0]   add_x;
    logic [N-1:0]   add_y;
    logic           add_cin;
    logic [N:0]     sum;
    logic           add_ovf;
    logic [N-1:0]   alu_res;
    logic           alu_carry;
    logic           alu_ovf;

    // An operation is taken only while idle; the multiplier is kicked off on
    // that same edge so its operands are captured exactly once.
    always_comb begin
        accept    = in_valid && in_ready && (state == IDLE);
        mul_start = accept && (opcode == OP_MUL);
    end

    seq_mul_shift_add #(.N(N)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // One (N+1)-bit adder serves ADD, SUB and ACC. SUB is A + ~B + 1, so the
    // adder carry-out is the inverse of the borrow. ACC routes the
    // accumulator into the first adder input instead of A.
    always_comb begin
        add_x   = (opcode == OP_ACC) ? acc : A;
        add_y   = (opcode == OP_SUB) ? ~B : ((opcode == OP_ACC) ? A : B);
        add_cin = (opcode == OP_SUB);
        sum     = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_cin};
        add_ovf = (add_x[N-1] == add_y[N-1]) && (sum[N-1] != add_x[N-1]);

        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (opcode)
            OP_ADD, OP_ACC: begin
                alu_res   = sum[N-1:0];
                alu_carry = sum[N];
                alu_ovf   = add_ovf;
            end
            OP_SUB: begin
                alu_res   = sum[N-1:0];
                alu_carry = ~sum[N];
                alu_ovf   = add_ovf;
            end
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_AND:  alu_res = A & B;
            default: alu_res = '0;
        endcase
    end

    // Control FSM. Single-cycle ops register their result on the accept edge
    // and go straight to DONE; MUL waits for the multiplier's final step and
    // captures the product on that edge. Handshake outputs are registered so
    // they only change on clock edges (or asynchronously on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (opcode == OP_MUL) begin
                            state <= MUL;
                        end else begin
                            result_q      <= alu_res;
                            flags_q.carry <= alu_carry;
                            flags_q.ovf   <= alu_ovf;
                            flags_q.zero  <= (alu_res == '0);
                            if (opcode == OP_ACC) acc <= alu_res;
                            if (opcode == OP_CLR) acc <= '0;
                            out_valid     <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result_q      <= mul_product[N-1:0];
                        flags_q.carry <= |mul_product[2*N-1:N];
                        flags_q.ovf   <= 1'b0;
                        flags_q.zero  <= (mul_product[N-1:0] == '0);
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else if (!mul_busy) begin
                        // Multiplier idle without finishing: recover to IDLE
                        // rather than waiting forever.
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign carry  = flags_q.carry;
    assign ovf    = flags_q.ovf;
    assign zero   = flags_q.zero;

endmodule

// File: tb/tb_alu_seq_acc.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_acc
// Directed bench for alu_seq_acc at N=4 with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alu_seq_acc;

    localparam int N = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ACC = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] A         = '0;
    logic [N-1:0] B         = '0;
    logic [2:0]   opcode    = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;

    int assertCount = 0;
    int failCount   = 0;

    alu_seq_acc #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int got, input int exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    // Present one operation, wait for its acceptance, scramble the inputs to
    // prove they were captured, then count edges until out_valid appears.
    task automatic applyStimulus(input logic [2:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b, output int lat,
                                 output bit readySeen);
        @(negedge clk);
        checkOutput("in_ready before accept", int'(in_ready), 1);
        opcode   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        A         = ~a;
        B         = ~b;
        opcode    = OP_CLR;
        lat       = 1;
        readySeen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) readySeen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) checkOutput("out_valid timeout", int'(out_valid), 1);
    endtask

    // Hand the result to the sink and confirm the block returns to IDLE
    task automatic takeResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " out_valid drop"}, int'(out_valid), 0);
        checkOutput({tag, " in_ready back"}, int'(in_ready), 1);
    endtask

    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input int expRes, input int expC, input int expV,
                         input int expZ, input int expLat);
        int lat;
        bit readySeen;
        applyStimulus(op, a, b, lat, readySeen);
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " result"}, int'(result), expRes);
        checkOutput({tag, " carry"}, int'(carry), expC);
        checkOutput({tag, " ovf"}, int'(ovf), expV);
        checkOutput({tag, " zero"}, int'(zero), expZ);
        if (op == OP_MUL) checkOutput({tag, " in_ready low while busy"}, int'(readySeen), 0);
        takeResult(tag);
    endtask

    initial begin
        int  lat;
        bit  readySeen;
        bit  staleSeen;

        // Reset state
        #12;
        checkOutput("reset in_ready", int'(in_ready), 1);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset result", int'(result), 0);
        checkOutput("reset carry", int'(carry), 0);
        checkOutput("reset ovf", int'(ovf), 0);
        checkOutput("reset zero", int'(zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic and flags
        runOp("ADD 9+8", OP_ADD, 4'd9, 4'd8, 1, 1, 1, 0, 1);
        runOp("SUB 3-5", OP_SUB, 4'd3, 4'd5, 14, 1, 0, 0, 1);
        runOp("SUB 5-5", OP_SUB, 4'd5, 4'd5, 0, 0, 0, 1, 1);

        // Multiplier: N+1 cycle latency
        runOp("MUL 5*3", OP_MUL, 4'd5, 4'd3, 15, 0, 0, 0, 5);
        runOp("MUL 7*5", OP_MUL, 4'd7, 4'd5, 3, 1, 0, 0, 5);

        // Accumulator wrap
        runOp("CLR", OP_CLR, 4'd3, 4'd3, 0, 0, 0, 1, 1);
        runOp("ACC +9", OP_ACC, 4'd9, 4'd0, 9, 0, 0, 0, 1);
        runOp("ACC +9 wrap", OP_ACC, 4'd9, 4'd0, 2, 1, 1, 0, 1);

        // Backpressure: result held while the sink stalls, new requests ignored
        applyStimulus(OP_OR, 4'hA, 4'h5, lat, readySeen);
        checkOutput("OR latency", lat, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode   = OP_ADD;
            A        = 4'd1;
            B        = 4'd1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checkOutput("stall out_valid held", int'(out_valid), 1);
            checkOutput("stall result held", int'(result), 15);
            checkOutput("stall in_ready low", int'(in_ready), 0);
        end
        takeResult("OR after stall");

        // Reset in the middle of a multiply (acc currently holds 2)
        @(negedge clk);
        opcode   = OP_MUL;
        A        = 4'd7;
        B        = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-MUL reset out_valid", int'(out_valid), 0);
        checkOutput("mid-MUL reset in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n     = 1'b1;
        staleSeen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) staleSeen = 1'b1;
        end
        checkOutput("no stale MUL output", int'(staleSeen), 0);
        runOp("ADD 1+1 after reset", OP_ADD, 4'd1, 4'd1, 2, 0, 0, 0, 1);
        runOp("ACC +3 after reset", OP_ACC, 4'd3, 4'd0, 3, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_seq_acc.md
# alu_seq_acc

Parametrised sequential ALU with a valid/ready front end, an internal accumulator, status flags and an iterative shift-add multiplier. It extends the combinational 4-op ALU to eight opcodes, N-bit width and multi-cycle operation. It sits between an operand source and a result sink in the datapath, and processes one operation at a time.

## Interface
- N, default 4: operand/result width; legal N >= 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and opcode present.
- in_ready  output  1  block accepts an operation; high only in IDLE.
- A  input  N  operand A, unsigned; signed (two's complement) for the overflow flag only.
- B  input  N  operand B, same interpretation as A.
- opcode  input  3  operation select.
- out_valid  output  1  result and flags valid; held until taken.
- out_ready  input  1  sink accepts the result.
- result  output  N  operation result.
- carry  output  1  carry/borrow/multiply-overflow.
- ovf  output  1  signed overflow.
- zero  output  1  result == 0.

## Operation
- Opcodes: 000 ADD A+B; 001 OR; 010 SUB A-B; 011 XOR; 100 AND; 101 ACC (acc <= acc+A, result = new acc); 110 MUL (low N bits of A*B); 111 CLR (acc <= 0, result 0).
- An operation is accepted when in_valid && in_ready. A, B and opcode are captured on the accepting edge, so later input changes have no effect.
- FSM states: IDLE, MUL, DONE.
  - IDLE, accept, opcode != MUL: compute, register the result and flags, go to DONE.
  - IDLE, accept, opcode == MUL: load the multiplicand, multiplier, a 2N-bit product of 0 and a counter of N, then go to MUL.
  - MUL: each cycle, add the multiplicand to the product if the multiplier LSB is 1, shift, and decrement the counter. When the counter reaches 0, register the result and go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Flags:
  - carry = adder carry-out for ADD/ACC, and borrow (A < B) for SUB. For MUL, carry is 1 if the product upper N bits are nonzero. It is 0 for logic ops and CLR.
  - ovf = signed overflow for ADD/SUB/ACC, and 0 otherwise.
  - zero = (result == 0) for all ops, so CLR gives zero = 1.
- The accumulator changes only on an accepted ACC or CLR. It wraps modulo 2^N, and the carry reports the wrap.
- Undefined opcodes do not exist, since all 8 codes are defined.

## Timing
- Reset (asynchronous assert, synchronous-release-safe): state IDLE, in_ready 1, out_valid 0, result 0, carry 0, ovf 0, zero 0, acc 0, counter 0.
- Latency from the accept edge to out_valid high:
  - 1 cycle for non-MUL ops.
  - N+1 cycles for MUL (N iteration cycles plus the DONE entry).
- out_valid stays high, with result and flags stable, until the cycle in which out_ready = 1. It drops on the next edge.
- in_ready is 0 in MUL and DONE. in_valid is ignored there, and no new operation is accepted in the same cycle as the result handoff. Maximum throughput is 1 op every 2 cycles (non-MUL).
- out_ready while out_valid = 0 has no effect.
- Reset during MUL or DONE: the operation is discarded, out_valid goes to 0 immediately, and acc is cleared. No stale result appears after release.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_CLR, 3 bits);
  - FSM state encoding (IDLE, MUL, DONE);
  - a flag bundle typedef {carry, ovf, zero}.
- One sub-module: seq_mul_shift_add, parameter N. Ports: clk, rst_n, start, a, b, busy, done, product[2N-1:0]. The top FSM sequences it and formats flags.
- Single-cycle ops use one (N+1)-bit adder shared by ADD/SUB/ACC, with SUB done as A + ~B + 1.

## Test plan
- N=4, ADD A=9, B=8: result 4'h1, carry 1, ovf 1, zero 0. out_valid rises 1 cycle after accept.
- N=4, SUB A=3, B=5: result 4'hE, carry 1, ovf 0. SUB A=5, B=5: result 0, zero 1, carry 0.
- N=4, MUL 5*3: result 4'hF, carry 0. MUL 7*5: result 4'h3, carry 1. out_valid appears exactly 5 cycles after accept, and in_ready stays 0 throughout.
- N=4 accumulator: CLR gives result 0, zero 1. Then ACC A=9 gives result 9, carry 0. Then ACC A=9 gives result 2, carry 1, ovf 1.
- Backpressure: hold out_ready = 0 for 3 cycles after an OR of 4'hA and 4'h5. Result stays 4'hF and out_valid stays 1, while in_valid pulses during the stall are not accepted. When out_ready = 1, IDLE is entered on the next edge.
- Reset during MUL cycle 2: out_valid 0 and in_ready 1 immediately, acc 0. After release, ADD 1+1 returns 2 with no stale MUL output.
